// File: rtl/clk_div_prog.sv
// clk_div_prog: run-time programmable clock divider with glitch-free ratio changes at period boundaries
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pending
);
  localparam logic [WIDTH-1:0] one_w = WIDTH'(1);
  localparam logic [WIDTH-1:0] two_w = WIDTH'(2);
  localparam logic [WIDTH-1:0] def_w = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH:0]   one_x = (WIDTH+1)'(1);
  logic [WIDTH-1:0] cnt, div_pend, div_sat, div_nxt;
  logic [WIDTH:0]   half, cnt_inc;
  logic             wrap;
  always_comb begin
    half    = ({1'b0, div_cur} + one_x) >> 1;
    cnt_inc = {1'b0, cnt} + one_x;
    div_sat = (div_in < two_w) ? two_w : div_in;
    div_nxt = pending ? div_pend : div_cur;
    wrap    = cnt == div_cur - one_w;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= def_w - one_w;
      div_cur  <= def_w;
      div_pend <= def_w;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (div_load) div_pend <= div_sat;
      pending <= div_load | (pending & en & ~wrap);
      if (!en) begin
        clk_out <= 1'b0;
        tick    <= 1'b0;
        div_cur <= div_nxt;
        cnt     <= div_nxt - one_w;
      end else if (wrap) begin
        clk_out <= 1'b1;
        tick    <= 1'b1;
        div_cur <= div_nxt;
        cnt     <= '0;
      end else begin
        clk_out <= cnt_inc < half;
        tick    <= 1'b0;
        cnt     <= cnt_inc[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed table-driven bench for clk_div_prog
module tb_clk_div_prog;
  typedef struct {
    logic       rst, en;
    logic [7:0] din;
    logic       ld;
    logic       co, tk;
    logic [7:0] dc;
    logic       pd;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b1, div_load = 1'b0;
  logic [7:0] div_in = '0;
  logic       clk_out, tick, pending;
  logic [7:0] div_cur;
  int         checks = 0, errors = 0;
  vec_t       vecs[$];
  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .div_cur(div_cur), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, e, input logic [7:0] di, input logic l,
                     input logic c, t, input logic [7:0] d, input logic p);
    vec_t v;
    v.rst = r; v.en = e; v.din = di; v.ld = l; v.co = c; v.tk = t; v.dc = d; v.pd = p;
    vecs.push_back(v);
  endtask
  task automatic apply(input string name, input vec_t v);
    rst = v.rst; en = v.en; div_in = v.din; div_load = v.ld;
    @(posedge clk);
    #1;
    checks++;
    if ({clk_out, tick, div_cur, pending} !== {v.co, v.tk, v.dc, v.pd}) begin
      errors++;
      $display("FAIL %s: got clk_out=%b tick=%b div_cur=%0d pending=%b, want clk_out=%b tick=%b div_cur=%0d pending=%b",
               name, clk_out, tick, div_cur, pending, v.co, v.tk, v.dc, v.pd);
    end
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 3; i++) add(1,1,0,0, 0,0,2,0);
    add(0,1,0,0, 1,1,2,0); add(0,1,0,0, 0,0,2,0); add(0,1,0,0, 1,1,2,0); add(0,1,0,0, 0,0,2,0);
    add(0,1,4,1, 1,1,2,1); add(0,1,0,0, 0,0,2,1); add(0,1,0,0, 1,1,4,0); add(0,1,0,0, 1,0,4,0);
    add(0,1,5,1, 0,0,4,1); add(0,1,0,0, 0,0,4,1); add(0,1,0,0, 1,1,5,0);
    add(0,1,0,0, 1,0,5,0); add(0,1,0,0, 1,0,5,0); add(0,1,0,0, 0,0,5,0); add(0,1,0,0, 0,0,5,0);
    add(0,1,0,0, 1,1,5,0);
    add(0,1,0,1, 1,0,5,1); add(0,1,0,0, 1,0,5,1); add(0,1,0,0, 0,0,5,1); add(0,1,0,0, 0,0,5,1);
    add(0,1,0,0, 1,1,2,0); add(0,1,0,0, 0,0,2,0);
    add(0,1,7,1, 1,1,2,1); add(0,1,3,1, 0,0,2,1); add(0,1,0,0, 1,1,3,0);
    add(0,1,0,0, 1,0,3,0); add(0,1,0,0, 0,0,3,0);
    add(0,1,6,1, 1,1,3,1); add(0,1,0,0, 1,0,3,1); add(0,1,0,0, 0,0,3,1); add(0,1,0,0, 1,1,6,0);
    add(0,1,0,0, 1,0,6,0); add(0,1,0,0, 1,0,6,0);
    add(0,1,0,0, 0,0,6,0); add(0,1,0,0, 0,0,6,0); add(0,1,0,0, 0,0,6,0);
    add(0,1,0,0, 1,1,6,0); add(0,1,0,0, 1,0,6,0);
    add(0,0,0,0, 0,0,6,0); add(0,0,0,0, 0,0,6,0);
    add(0,1,0,0, 1,1,6,0); add(0,1,0,0, 1,0,6,0); add(0,1,0,0, 1,0,6,0);
    add(0,1,0,0, 0,0,6,0); add(0,1,0,0, 0,0,6,0); add(0,1,0,0, 0,0,6,0);
    add(0,1,0,0, 1,1,6,0);
    add(0,0,4,1, 0,0,6,1); add(0,0,0,0, 0,0,4,0);
    add(0,1,0,0, 1,1,4,0); add(0,1,0,0, 1,0,4,0); add(0,1,0,0, 0,0,4,0);
    add(0,1,255,1, 0,0,4,1); add(1,1,0,0, 0,0,2,0); add(0,1,0,0, 1,1,2,0); add(0,1,0,0, 0,0,2,0);
    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);
    v.rst = 0; v.en = 0; v.din = 8'd255; v.ld = 1; v.co = 0; v.tk = 0; v.dc = 8'd2; v.pd = 1;
    apply("max_load", v);
    v.din = 0; v.ld = 0; v.dc = 8'd255; v.pd = 0;
    apply("max_idle_apply", v);
    v.en = 1; v.co = 1; v.tk = 1;
    apply("max_first_wrap", v);
    for (int i = 1; i < 255; i++) begin
      v.co = (i < 128); v.tk = 0;
      apply($sformatf("max_cnt%0d", i), v);
    end
    v.co = 1; v.tk = 1;
    apply("max_second_wrap", v);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
